// File: rtl/emmc_xfer_ctrl.sv
// eMMC card controller: power-up/identification, bus setup, then single/multi-block transfers.
// Optional high-speed switch (CMD6 HS_TIMING + sel_clk_o) is built when EMMC_XFER_HS_EN is defined.
module emmc_xfer_ctrl #(
    parameter int unsigned BUS_WIDTH      = 8,
    parameter int unsigned BLK_CNT_W      = 16,
    parameter int unsigned POWERUP_CYCLES = 450,
    parameter logic [15:0] RCA            = 16'h0004,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned OCR_POLL_MAX   = 4095
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    output logic                 cmdh_start_o,
    output logic [5:0]           cmdh_idx_o,
    output logic [31:0]          cmdh_arg_o,
    output logic                 cmdh_int_rst_o,
    input  logic                 cmdh_cc_i,
    input  logic                 cmdh_err_i,
    input  logic [31:0]          cmdh_resp0_i,
    output logic                 dath_read_o,
    output logic                 dath_write_o,
    output logic                 dath_stop_o,
    output logic [1:0]           dath_bus_size_o,
    input  logic                 dath_busy_i,
    input  logic                 dath_fsm_busy_i,
    input  logic                 dath_crc_ok_i,
    output logic                 sel_clk_o,
    input  logic                 start_i,
    input  logic                 we_i,
    input  logic [31:0]          addr_i,
    input  logic [BLK_CNT_W-1:0] nblk_i,
    output logic                 ready_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [2:0]           err_code_o,
    input  logic                 err_clr_i
);

    typedef enum logic [3:0] {
        ST_START, ST_CMD0, ST_CMD1, ST_CMD2, ST_CMD3, ST_CMD7, ST_HS, ST_WIDTH,
        ST_IDLE, ST_XCMD, ST_XDAT, ST_STOP, ST_WAIT_CMD, ST_WAIT_BUSY, ST_ERR
    } state_t;

    localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int unsigned OCR_W   = $clog2(OCR_POLL_MAX + 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
    localparam logic [OCR_W-1:0]   OCR_LAST  = OCR_W'(OCR_POLL_MAX - 1);
    localparam logic [20:0]        PWR_LAST  = 21'(POWERUP_CYCLES - 1);
    localparam logic [20:0]        BUSY_MAX  = 21'h100000;
    localparam logic [1:0]         BW_CODE   = (BUS_WIDTH == 8) ? 2'd2 : (BUS_WIDTH == 4) ? 2'd1 : 2'd0;

    state_t state_q, state_d, ret_q, ret_d;
    logic [20:0]          cnt_q, cnt_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [OCR_W-1:0]     ocr_q, ocr_d;
    logic                 we_q, we_d, multi_q, multi_d, pend_q, pend_d;
    logic                 fbusy_q, init_q, init_d;
    logic [31:0]          addr_q, addr_d;
    logic [BLK_CNT_W-1:0] rem_q, rem_d;
    logic                 start_q, start_d, int_rst_q, int_rst_d;
    logic [5:0]           idx_q, idx_d;
    logic [31:0]          arg_q, arg_d;
    logic                 rd_q, rd_d, wr_q, wr_d, stop_q, stop_d;
    logic [1:0]           bus_q, bus_d;
    logic                 sel_q, sel_d, ready_q, ready_d, done_q, done_d, err_q, err_d;
    logic [2:0]           code_q, code_d;
    logic                 issue, blk_done;
    logic                 unused_resp;

    assign unused_resp = ^cmdh_resp0_i[30:0];
    assign blk_done    = fbusy_q & ~dath_fsm_busy_i;

    always_comb begin
        state_d = state_q;  ret_d   = ret_q;   cnt_d   = '0;
        retry_d = retry_q;  ocr_d   = ocr_q;   we_d    = we_q;
        multi_d = multi_q;  pend_d  = 1'b0;    addr_d  = addr_q;
        rem_d   = rem_q;    start_d = 1'b0;    idx_d   = idx_q;
        arg_d   = arg_q;    rd_d    = 1'b0;    wr_d    = 1'b0;
        stop_d  = 1'b0;     bus_d   = bus_q;   sel_d   = sel_q;
        done_d  = 1'b0;     code_d  = code_q;  issue   = 1'b0;
        case (state_q)
            ST_START: begin
                cnt_d = cnt_q + 21'd1;
                if (cnt_q == PWR_LAST) state_d = ST_CMD0;
            end
            ST_CMD0:  begin idx_d = 6'd0; arg_d = '0;                 issue = 1'b1; end
            ST_CMD1:  begin idx_d = 6'd1; arg_d = 32'h40FF8080;       issue = 1'b1; end
            ST_CMD2:  begin idx_d = 6'd2; arg_d = '0;                 issue = 1'b1; end
            ST_CMD3:  begin idx_d = 6'd3; arg_d = {RCA, 16'h0000};    issue = 1'b1; end
            ST_CMD7:  begin idx_d = 6'd7; arg_d = {RCA, 16'h0000};    issue = 1'b1; end
            ST_HS:    begin idx_d = 6'd6; arg_d = 32'h03B90100;       issue = 1'b1; end
            ST_WIDTH: begin
                idx_d = 6'd6; arg_d = {16'h03B7, 6'b0, BW_CODE, 8'h00}; issue = 1'b1;
            end
            ST_XCMD: begin
                idx_d = multi_q ? (we_q ? 6'd25 : 6'd18) : (we_q ? 6'd24 : 6'd17);
                arg_d = addr_q;
                issue = 1'b1;
            end
            ST_STOP:  begin idx_d = 6'd12; arg_d = '0; stop_d = 1'b1; issue = 1'b1; end
            ST_IDLE: begin
                if (start_i && (nblk_i != '0)) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    rem_d   = nblk_i;
                    multi_d = (nblk_i != BLK_CNT_W'(1));
                    state_d = ST_XCMD;
                end
            end
            ST_WAIT_CMD: begin
                // error takes priority over a coincident completion and reissues the same command
                if (cmdh_err_i) begin
                    if (retry_q == RETRY_MAX) begin
                        retry_d = '0; code_d = 3'd1; state_d = ST_ERR;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1); state_d = ret_q;
                    end
                end else if (cmdh_cc_i) begin
                    retry_d = '0;
                    case (ret_q)
                        ST_CMD0: state_d = ST_CMD1;
                        ST_CMD1: begin
                            if (cmdh_resp0_i[31]) begin
                                ocr_d = '0; state_d = ST_CMD2;
                            end else if (ocr_q == OCR_LAST) begin
                                ocr_d = '0; code_d = 3'd2; state_d = ST_ERR;
                            end else begin
                                ocr_d = ocr_q + OCR_W'(1); state_d = ST_CMD1;
                            end
                        end
                        ST_CMD2: state_d = ST_CMD3;
                        ST_CMD3: state_d = ST_CMD7;
                        ST_CMD7: begin
`ifdef EMMC_XFER_HS_EN
                            state_d = ST_HS;
`else
                            if (BUS_WIDTH == 1) state_d = ST_IDLE;
                            else                state_d = ST_WIDTH;
`endif
                        end
                        ST_HS, ST_WIDTH: state_d = ST_WAIT_BUSY;
                        ST_XCMD: begin state_d = ST_XDAT; pend_d = 1'b1; end
                        ST_STOP: begin
                            if (we_q) state_d = ST_WAIT_BUSY;
                            else begin done_d = 1'b1; state_d = ST_IDLE; end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_XDAT: begin
                if (pend_q) begin
                    rd_d = ~we_q;
                    wr_d = we_q;
                end else if (blk_done) begin
                    if (!dath_crc_ok_i) begin
                        code_d = 3'd3; state_d = ST_ERR;
                    end else begin
                        rem_d = rem_q - BLK_CNT_W'(1);
                        if (rem_q == BLK_CNT_W'(1)) begin
                            if (multi_q) state_d = ST_STOP;
                            else if (we_q) begin ret_d = ST_XDAT; state_d = ST_WAIT_BUSY; end
                            else begin done_d = 1'b1; state_d = ST_IDLE; end
                        end else begin
                            pend_d = 1'b1;
                        end
                    end
                end
            end
            ST_WAIT_BUSY: begin
                cnt_d = cnt_q + 21'd1;
                if (!dath_busy_i) begin
                    case (ret_q)
                        ST_HS: begin
`ifdef EMMC_XFER_HS_EN
                            sel_d = 1'b1;
`endif
                            if (BUS_WIDTH == 1) state_d = ST_IDLE;
                            else                state_d = ST_WIDTH;
                        end
                        ST_WIDTH: begin bus_d = BW_CODE; state_d = ST_IDLE; end
                        default:  begin done_d = 1'b1; state_d = ST_IDLE; end
                    endcase
                end else if (cnt_q == BUSY_MAX) begin
                    code_d = 3'd4; state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                if (err_clr_i) begin
                    code_d  = '0;
                    state_d = init_q ? ST_IDLE : ST_START;
                end
            end
            default: state_d = ST_START;
        endcase
        if (issue) begin
            start_d = 1'b1;
            ret_d   = state_q;
            state_d = ST_WAIT_CMD;
        end
        int_rst_d = (state_d != state_q);
        err_d     = (state_d == ST_ERR);
        ready_d   = (state_q == ST_IDLE) && (state_d == ST_IDLE);
        init_d    = init_q | (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= ST_START;  ret_q   <= ST_START; cnt_q  <= '0;
            retry_q <= '0;        ocr_q   <= '0;       we_q   <= 1'b0;
            multi_q <= 1'b0;      pend_q  <= 1'b0;     fbusy_q <= 1'b0;
            init_q  <= 1'b0;      addr_q  <= '0;       rem_q  <= '0;
            start_q <= 1'b0;      int_rst_q <= 1'b0;   idx_q  <= '0;
            arg_q   <= '0;        rd_q    <= 1'b0;     wr_q   <= 1'b0;
            stop_q  <= 1'b0;      bus_q   <= '0;       sel_q  <= 1'b0;
            ready_q <= 1'b0;      done_q  <= 1'b0;     err_q  <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;   ret_q   <= ret_d;    cnt_q  <= cnt_d;
            retry_q <= retry_d;   ocr_q   <= ocr_d;    we_q   <= we_d;
            multi_q <= multi_d;   pend_q  <= pend_d;   fbusy_q <= dath_fsm_busy_i;
            init_q  <= init_d;    addr_q  <= addr_d;   rem_q  <= rem_d;
            start_q <= start_d;   int_rst_q <= int_rst_d; idx_q <= idx_d;
            arg_q   <= arg_d;     rd_q    <= rd_d;     wr_q   <= wr_d;
            stop_q  <= stop_d;    bus_q   <= bus_d;    sel_q  <= sel_d;
            ready_q <= ready_d;   done_q  <= done_d;   err_q  <= err_d;
            code_q  <= code_d;
        end
    end

    assign cmdh_start_o    = start_q;
    assign cmdh_idx_o      = idx_q;
    assign cmdh_arg_o      = arg_q;
    assign cmdh_int_rst_o  = int_rst_q;
    assign dath_read_o     = rd_q;
    assign dath_write_o    = wr_q;
    assign dath_stop_o     = stop_q;
    assign dath_bus_size_o = bus_q;
    assign sel_clk_o       = sel_q;
    assign ready_o         = ready_q;
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign err_code_o      = code_q;

endmodule

// File: tb/tb_emmc_xfer_ctrl.sv
// Directed bench for emmc_xfer_ctrl with a small card / data-host model.
`timescale 1ns/1ps
module tb_emmc_xfer_ctrl;
    logic        clk_i = 1'b0;
    logic        arst_i;
    logic        cmdh_start_o, cmdh_int_rst_o, cmdh_cc_i, cmdh_err_i;
    logic [5:0]  cmdh_idx_o;
    logic [31:0] cmdh_arg_o, cmdh_resp0_i;
    logic        dath_read_o, dath_write_o, dath_stop_o;
    logic [1:0]  dath_bus_size_o;
    logic        dath_busy_i, dath_fsm_busy_i, dath_crc_ok_i;
    logic        sel_clk_o, start_i, we_i, ready_o, done_o, err_o, err_clr_i;
    logic [31:0] addr_i;
    logic [15:0] nblk_i;
    logic [2:0]  err_code_o;

    int unsigned tests = 0, fails = 0;
    logic [5:0]  log_idx[$];
    logic [31:0] log_arg[$];
    int unsigned log_blk[$];
    int unsigned cyc = 0, cmd_busy_end = 0, dat_busy_end = 0;
    int unsigned ocr_limit, ocr_given, err_limit, err_given, err_idx;
    int unsigned crc_fail_blk, blk_num;
    int unsigned n_rd = 0, n_wr = 0, n_stop = 0, n_done = 0;
    logic        cur_we;
    logic [5:0]  m_idx;
    logic        m_wr;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;
    assign dath_busy_i = (cyc < cmd_busy_end) || (cyc < dat_busy_end);

    always @(negedge clk_i) begin
        if (dath_read_o)  n_rd++;
        if (dath_write_o) n_wr++;
        if (dath_stop_o)  n_stop++;
        if (done_o)       n_done++;
    end

    emmc_xfer_ctrl #(.BUS_WIDTH(8), .BLK_CNT_W(16), .POWERUP_CYCLES(20), .RCA(16'h0004),
                     .MAX_RETRIES(3), .OCR_POLL_MAX(4095)) dut (
        .clk_i(clk_i), .arst_i(arst_i),
        .cmdh_start_o(cmdh_start_o), .cmdh_idx_o(cmdh_idx_o), .cmdh_arg_o(cmdh_arg_o),
        .cmdh_int_rst_o(cmdh_int_rst_o), .cmdh_cc_i(cmdh_cc_i), .cmdh_err_i(cmdh_err_i),
        .cmdh_resp0_i(cmdh_resp0_i), .dath_read_o(dath_read_o), .dath_write_o(dath_write_o),
        .dath_stop_o(dath_stop_o), .dath_bus_size_o(dath_bus_size_o), .dath_busy_i(dath_busy_i),
        .dath_fsm_busy_i(dath_fsm_busy_i), .dath_crc_ok_i(dath_crc_ok_i), .sel_clk_o(sel_clk_o),
        .start_i(start_i), .we_i(we_i), .addr_i(addr_i), .nblk_i(nblk_i), .ready_o(ready_o),
        .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o), .err_clr_i(err_clr_i)
    );

    // card command model: logs each command, answers after 2 cycles
    initial begin
        cmdh_cc_i = 0; cmdh_err_i = 0; cmdh_resp0_i = 0; ocr_given = 0; err_given = 0;
        forever begin
            @(posedge clk_i); #1;
            if (cmdh_start_o) begin
                m_idx = cmdh_idx_o;
                log_idx.push_back(cmdh_idx_o);
                log_arg.push_back(cmdh_arg_o);
                log_blk.push_back(blk_num);
                repeat (2) @(posedge clk_i);
                #1;
                cmdh_resp0_i = 32'h80FF8080;
                if (m_idx == 6'd1 && ocr_given < ocr_limit) begin
                    ocr_given++;
                    cmdh_resp0_i = 32'h00FF8080;
                end
                if (m_idx == 6'(err_idx) && err_given < err_limit) begin
                    err_given++;
                    cmdh_err_i = 1;
                end
                cmdh_cc_i = 1;
                if (!cmdh_err_i && (m_idx == 6'd6 || (m_idx == 6'd12 && cur_we)))
                    cmd_busy_end = cyc + 4;
                @(posedge clk_i); #1;
                cmdh_cc_i = 0; cmdh_err_i = 0;
            end
        end
    end

    // data host model: each strobe runs a 6-cycle block; writes leave the card busy
    initial begin
        dath_fsm_busy_i = 0; dath_crc_ok_i = 1; blk_num = 0;
        forever begin
            @(posedge clk_i); #1;
            if (dath_read_o || dath_write_o) begin
                m_wr = dath_write_o;
                blk_num++;
                dath_fsm_busy_i = 1;
                repeat (6) @(posedge clk_i);
                #1;
                dath_crc_ok_i   = (blk_num != crc_fail_blk);
                dath_fsm_busy_i = 0;
                if (m_wr) dat_busy_end = cyc + 4;
            end
        end
    end

    task automatic test_reset();
        arst_i = 1;
        repeat (3) @(posedge clk_i);
        #1;
        tests++;
        if ({cmdh_start_o, cmdh_int_rst_o, dath_read_o, dath_write_o, dath_stop_o} !== 5'b0) begin
            fails++; $display("FAIL rst_strobes: got %b, required 00000",
                {cmdh_start_o, cmdh_int_rst_o, dath_read_o, dath_write_o, dath_stop_o});
        end
        tests++;
        if ({sel_clk_o, ready_o, done_o, err_o} !== 4'b0) begin
            fails++; $display("FAIL rst_status: sel/ready/done/err=%b, required 0000",
                {sel_clk_o, ready_o, done_o, err_o});
        end
        tests++;
        if (dath_bus_size_o !== 2'd0 || err_code_o !== 3'd0 || cmdh_idx_o !== 6'd0 || cmdh_arg_o !== 32'd0) begin
            fails++; $display("FAIL rst_fields: bus=%0d code=%0d idx=%0d arg=%h, required all 0",
                dath_bus_size_o, err_code_o, cmdh_idx_o, cmdh_arg_o);
        end
    endtask

    task automatic test_powerup();
        logic [5:0]  exp_idx[$];
        logic [31:0] exp_arg[$];
        int unsigned base, n;
        exp_idx.push_back(6'd0); exp_arg.push_back(32'h0);
        for (int i = 0; i < 4; i++) begin exp_idx.push_back(6'd1); exp_arg.push_back(32'h40FF8080); end
        exp_idx.push_back(6'd2); exp_arg.push_back(32'h0);
        exp_idx.push_back(6'd3); exp_arg.push_back(32'h00040000);
        exp_idx.push_back(6'd7); exp_arg.push_back(32'h00040000);
`ifdef EMMC_XFER_HS_EN
        exp_idx.push_back(6'd6); exp_arg.push_back(32'h03B90100);
`endif
        exp_idx.push_back(6'd6); exp_arg.push_back(32'h03B70200);
        ocr_limit = ocr_given + 3;
        base = log_idx.size();
        arst_i = 0;
        repeat (15) @(posedge clk_i);
        #1;
        tests++;
        if (log_idx.size() != base) begin
            fails++; $display("FAIL pwr_wait: %0d commands during power-up wait, required 0", log_idx.size() - base);
        end
        n = 0;
        while (!ready_o && n < 3000) begin @(posedge clk_i); #1; n++; end
        tests++;
        if (ready_o !== 1'b1) begin
            fails++; $display("FAIL pwr_ready: ready_o=%b after %0d cycles, required 1", ready_o, n);
        end
        tests++;
        if (log_idx.size() != base + exp_idx.size()) begin
            fails++; $display("FAIL pwr_cmd_count: %0d commands, required %0d", log_idx.size() - base, exp_idx.size());
        end
        for (int i = 0; i < exp_idx.size(); i++) begin
            if (base + i < log_idx.size()) begin
                tests++;
                if (log_idx[base+i] !== exp_idx[i] || log_arg[base+i] !== exp_arg[i]) begin
                    fails++; $display("FAIL pwr_cmd[%0d]: CMD%0d arg %h, required CMD%0d arg %h",
                        i, log_idx[base+i], log_arg[base+i], exp_idx[i], exp_arg[i]);
                end
            end
        end
        tests++;
        if (dath_bus_size_o !== 2'd2) begin
            fails++; $display("FAIL pwr_bus_size: got %0d, required 2", dath_bus_size_o);
        end
        tests++;
`ifdef EMMC_XFER_HS_EN
        if (sel_clk_o !== 1'b1) begin
            fails++; $display("FAIL pwr_sel_clk: got %b, required 1", sel_clk_o);
        end
`else
        if (sel_clk_o !== 1'b0) begin
            fails++; $display("FAIL pwr_sel_clk: got %b, required 0", sel_clk_o);
        end
`endif
    endtask

    task automatic test_read_single();
        int unsigned base, brd, bst, bdn, n;
        base = log_idx.size(); brd = n_rd; bst = n_stop; bdn = n_done;
        cur_we = 0; we_i = 0; addr_i = 32'h100; nblk_i = 16'd1; start_i = 1;
        @(posedge clk_i); #1;
        start_i = 0;
        n = 0;
        while (!done_o && n < 500) begin @(posedge clk_i); #1; n++; end
        tests++;
        if (done_o !== 1'b1 || ready_o !== 1'b0) begin
            fails++; $display("FAIL rd1_done: done=%b ready=%b after %0d cycles, required done=1 ready=0", done_o, ready_o, n);
        end
        @(posedge clk_i); #1;
        tests++;
        if (done_o !== 1'b0 || ready_o !== 1'b1) begin
            fails++; $display("FAIL rd1_after: done=%b ready=%b, required done=0 ready=1", done_o, ready_o);
        end
        tests++;
        if (log_idx.size() != base + 1 || log_idx[base] !== 6'd17 || log_arg[base] !== 32'h100) begin
            fails++; $display("FAIL rd1_cmd: %0d cmds, first CMD%0d arg %h, required 1 cmd CMD17 arg 00000100",
                log_idx.size() - base, log_idx[base], log_arg[base]);
        end
        tests++;
        if (n_rd - brd != 1 || n_stop != bst || n_done - bdn != 1) begin
            fails++; $display("FAIL rd1_strobes: rd=%0d stop=%0d done=%0d, required 1 0 1",
                n_rd - brd, n_stop - bst, n_done - bdn);
        end
    endtask

    task automatic test_write_multi();
        int unsigned base, bwr, bst, bblk, n;
        base = log_idx.size(); bwr = n_wr; bst = n_stop; bblk = blk_num;
        cur_we = 1; we_i = 1; addr_i = 32'h200; nblk_i = 16'd3; start_i = 1;
        @(posedge clk_i); #1;
        start_i = 0;
        n = 0;
        while (!done_o && n < 1000) begin @(posedge clk_i); #1; n++; end
        tests++;
        if (done_o !== 1'b1 || dath_busy_i !== 1'b0) begin
            fails++; $display("FAIL wr3_done: done=%b busy=%b after %0d cycles, required done=1 busy=0", done_o, dath_busy_i, n);
        end
        tests++;
        if (log_idx.size() != base + 2 || log_idx[base] !== 6'd25 || log_arg[base] !== 32'h200) begin
            fails++; $display("FAIL wr3_cmd: %0d cmds, first CMD%0d arg %h, required 2 cmds starting CMD25 arg 00000200",
                log_idx.size() - base, log_idx[base], log_arg[base]);
        end
        if (log_idx.size() > base + 1) begin
            tests++;
            if (log_idx[base+1] !== 6'd12 || log_blk[base+1] - bblk != 3) begin
                fails++; $display("FAIL wr3_stop: CMD%0d after %0d blocks, required CMD12 after 3",
                    log_idx[base+1], log_blk[base+1] - bblk);
            end
        end
        tests++;
        if (n_wr - bwr != 3 || n_stop - bst != 1) begin
            fails++; $display("FAIL wr3_strobes: wr=%0d stop=%0d, required 3 1", n_wr - bwr, n_stop - bst);
        end
        @(posedge clk_i); #1;
        tests++;
        if (ready_o !== 1'b1) begin
            fails++; $display("FAIL wr3_ready: got %b, required 1", ready_o);
        end
    endtask

    task automatic test_nblk_zero();
        int unsigned base;
        base = log_idx.size();
        we_i = 0; addr_i = 32'h400; nblk_i = 16'd0; start_i = 1;
        @(posedge clk_i); #1;
        start_i = 0;
        repeat (20) @(posedge clk_i);
        #1;
        tests++;
        if (log_idx.size() != base || ready_o !== 1'b1) begin
            fails++; $display("FAIL nblk0: %0d cmds ready=%b, required 0 cmds ready=1", log_idx.size() - base, ready_o);
        end
    endtask

    task automatic test_crc_err();
        int unsigned base, brd, n;
        base = log_idx.size(); brd = n_rd;
        crc_fail_blk = blk_num + 2;
        cur_we = 0; we_i = 0; addr_i = 32'h300; nblk_i = 16'd3; start_i = 1;
        @(posedge clk_i); #1;
        start_i = 0;
        n = 0;
        while (!err_o && n < 1000) begin @(posedge clk_i); #1; n++; end
        tests++;
        if (err_o !== 1'b1 || err_code_o !== 3'd3) begin
            fails++; $display("FAIL crc_err: err=%b code=%0d after %0d cycles, required err=1 code=3", err_o, err_code_o, n);
        end
        tests++;
        if (n_rd - brd != 2 || log_idx[base] !== 6'd18) begin
            fails++; $display("FAIL crc_blocks: %0d reads first CMD%0d, required 2 reads CMD18", n_rd - brd, log_idx[base]);
        end
        crc_fail_blk = 0;
        err_clr_i = 1;
        @(posedge clk_i); #1;
        err_clr_i = 0;
        @(posedge clk_i); #1;
        tests++;
        if (ready_o !== 1'b1 || err_o !== 1'b0 || log_idx.size() != base + 1) begin
            fails++; $display("FAIL crc_clr: ready=%b err=%b cmds=%0d, required ready=1 err=0 cmds=1",
                ready_o, err_o, log_idx.size() - base);
        end
    endtask

    task automatic test_retry_reset();
        int unsigned base, n3, n;
        err_idx = 3; err_limit = err_given + 4; ocr_limit = ocr_given;
        arst_i = 1;
        repeat (2) @(posedge clk_i);
        #1;
        arst_i = 0;
        base = log_idx.size();
        n = 0;
        while (!err_o && n < 3000) begin @(posedge clk_i); #1; n++; end
        tests++;
        if (err_o !== 1'b1 || err_code_o !== 3'd1) begin
            fails++; $display("FAIL retry_err: err=%b code=%0d after %0d cycles, required err=1 code=1", err_o, err_code_o, n);
        end
        n3 = 0;
        for (int i = base; i < log_idx.size(); i++) if (log_idx[i] == 6'd3) n3++;
        tests++;
        if (n3 != 4 || log_idx[log_idx.size()-1] !== 6'd3) begin
            fails++; $display("FAIL retry_count: %0d CMD3 issued, last CMD%0d, required 4 and last CMD3",
                n3, log_idx[log_idx.size()-1]);
        end
        arst_i = 1;
        #1;
        tests++;
        if ({sel_clk_o, ready_o, done_o, err_o, cmdh_start_o} !== 5'b0 || dath_bus_size_o !== 2'd0 || err_code_o !== 3'd0) begin
            fails++; $display("FAIL arst_clear: sel/ready/done/err/start=%b bus=%0d code=%0d, required all 0",
                {sel_clk_o, ready_o, done_o, err_o, cmdh_start_o}, dath_bus_size_o, err_code_o);
        end
        @(posedge clk_i); #1;
        arst_i = 0;
        n = 0;
        while (!ready_o && n < 3000) begin @(posedge clk_i); #1; n++; end
        tests++;
        if (ready_o !== 1'b1 || dath_bus_size_o !== 2'd2) begin
            fails++; $display("FAIL reinit: ready=%b bus=%0d after %0d cycles, required ready=1 bus=2", ready_o, dath_bus_size_o, n);
        end
    endtask

    initial begin
        arst_i = 1; start_i = 0; we_i = 0; addr_i = 0; nblk_i = 0; err_clr_i = 0;
        cur_we = 0; crc_fail_blk = 0; ocr_limit = 0; err_limit = 0; err_idx = 99;
        test_reset();
        test_powerup();
        test_read_single();
        test_write_multi();
        test_nblk_zero();
        test_crc_err();
        test_retry_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
